branch_resolve_ctrl: RTL and testbench

Sequencing controller for the ID-stage branch comparator (`BTypeOperate`) in the 5-stage MIPS pipeline. It detects data hazards on a decoded branch's source registers and stalls the front end until the operands can be forwarded. It drives the comparator's operand-forwarding selects and op code, consumes `BResult`, and issues the PC redirect and IF flush. It also keeps branch and taken-branch statistics counters.

---
 rtl/branch_resolve_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_branch_resolve_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: sequencing controller for the ID-stage branch comparator.
// Detects RAW hazards on a decoded branch's rs/rt, stalls the front end until the
// operands can be forwarded, drives the comparator op and forwarding selects, and
// issues the PC redirect / IF flush. Keeps branch and taken-branch counters.
//
// Ports:
//   i_clk, i_rst                   clock, async active-high reset
//   i_pipe_flush                   pipeline-wide flush, aborts a pending branch
//   i_id_*                         decoded ID-stage instruction (branch fields)
//   i_ex_*, i_mem_*, i_wb_*        destination info of the later stages
//   i_b_result                     comparator result
//   o_btype_op_out                 op code to the comparator (pass-through)
//   o_fwd_a_sel, o_fwd_b_sel       0 = regfile, 1 = MEM ALU result, 2 = WB result
//   o_stall                        hold PC and IF/ID, bubble into EX
//   o_pc_redirect, o_if_flush      taken branch this cycle
//   o_redirect_target              PC+4 + (imm << 2)
//   o_illegal_op                   pulse on resolution of an unsupported op
//   o_branch_cnt, o_taken_cnt      statistics counters (wrapping)
module branch_resolve_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter logic [2:0]  BTypeBeq  = 3'd0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pipe_flush,
  input  logic             i_id_valid,
  input  logic             i_id_is_branch,
  input  logic [2:0]       i_id_btype_op,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic [31:0]      i_id_pc_plus4,
  input  logic [31:0]      i_id_imm,
  input  logic             i_ex_regwrite,
  input  logic             i_ex_memread,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_mem_regwrite,
  input  logic             i_mem_memread,
  input  logic [4:0]       i_mem_rd,
  input  logic             i_wb_regwrite,
  input  logic [4:0]       i_wb_rd,
  input  logic             i_b_result,
  output logic [2:0]       o_btype_op_out,
  output logic [1:0]       o_fwd_a_sel,
  output logic [1:0]       o_fwd_b_sel,
  output logic             o_stall,
  output logic             o_pc_redirect,
  output logic             o_if_flush,
  output logic [31:0]      o_redirect_target,
  output logic             o_illegal_op,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_taken_cnt
);

  typedef enum logic [0:0] {StIdle, StStall} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic             r_cnt;
  logic             w_cnt_next;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_taken_cnt;

  // Extra cycles a source register must wait before it can be forwarded.
  function automatic logic [1:0] hazard_need(
    input logic [4:0] r,
    input logic ex_rw, input logic ex_mr, input logic [4:0] ex_rd,
    input logic mem_rw, input logic mem_mr, input logic [4:0] mem_rd
  );
    logic [1:0] n;
    n = 2'd0;
    if (r != 5'd0) begin
      if (ex_rw && ex_mr && ex_rd == r) begin
        n = 2'd2;
      end else if ((ex_rw && !ex_mr && ex_rd == r) || (mem_rw && mem_mr && mem_rd == r)) begin
        n = 2'd1;
      end
    end
    return n;
  endfunction

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] r,
    input logic mem_rw, input logic mem_mr, input logic [4:0] mem_rd,
    input logic wb_rw, input logic [4:0] wb_rd
  );
    logic [1:0] f;
    f = 2'd0;
    if (r != 5'd0) begin
      if (mem_rw && !mem_mr && mem_rd == r) begin
        f = 2'd1;
      end else if (wb_rw && wb_rd == r) begin
        f = 2'd2;
      end
    end
    return f;
  endfunction

  logic [1:0] w_need_a;
  logic [1:0] w_need_b;
  logic [1:0] w_need;
  logic       w_branch;
  logic       w_active;
  logic       w_resolve;
  logic       w_is_beq;
  logic       w_taken;
  logic       w_unused_imm;

  assign w_need_a = hazard_need(i_id_rs, i_ex_regwrite, i_ex_memread, i_ex_rd,
                                i_mem_regwrite, i_mem_memread, i_mem_rd);
  assign w_need_b = hazard_need(i_id_rt, i_ex_regwrite, i_ex_memread, i_ex_rd,
                                i_mem_regwrite, i_mem_memread, i_mem_rd);
  assign w_need   = (w_need_a > w_need_b) ? w_need_a : w_need_b;
  assign w_branch = i_id_valid & i_id_is_branch;
  // Control outputs are suppressed while flushing or held in reset.
  assign w_active = !i_pipe_flush & !i_rst;
  assign w_is_beq = (i_id_btype_op == BTypeBeq);

  assign w_resolve = w_active &
                     (((r_state == StIdle) & w_branch & (w_need == 2'd0)) |
                      ((r_state == StStall) & !r_cnt));
  assign w_taken   = w_resolve & i_b_result & w_is_beq;

  // Upper offset bits fall off the word-to-byte shift.
  assign w_unused_imm = ^i_id_imm[31:30];

  // State, stall countdown and statistics registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= 1'b0;
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_resolve) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_taken) begin
        r_taken_cnt <= r_taken_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    if (i_pipe_flush) begin
      w_state_next = StIdle;
      w_cnt_next   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_branch && w_need != 2'd0) begin
            w_state_next = StStall;
            w_cnt_next   = (w_need == 2'd2);  // s - 1
          end
        end
        StStall: begin
          if (r_cnt) begin
            w_cnt_next = 1'b0;
          end else begin
            w_state_next = StIdle;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    o_stall = 1'b0;
    if (w_active) begin
      unique case (r_state)
        StIdle:  o_stall = w_branch & (w_need != 2'd0);
        StStall: o_stall = r_cnt;
        default: o_stall = 1'b0;
      endcase
    end
    o_pc_redirect     = w_taken;
    o_if_flush        = w_taken;
    o_illegal_op      = w_resolve & !w_is_beq;
    o_fwd_a_sel       = fwd_sel(i_id_rs, i_mem_regwrite, i_mem_memread, i_mem_rd,
                                i_wb_regwrite, i_wb_rd);
    o_fwd_b_sel       = fwd_sel(i_id_rt, i_mem_regwrite, i_mem_memread, i_mem_rd,
                                i_wb_regwrite, i_wb_rd);
    o_redirect_target = i_id_pc_plus4 + {i_id_imm[29:0], 2'b00};
    o_btype_op_out    = i_id_btype_op;
  end

  assign o_branch_cnt = r_branch_cnt;
  assign o_taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: stimulus pushes the hand-computed
// expected outputs for each cycle; a negedge monitor pops and compares.
module tb_branch_resolve_ctrl;

  localparam int unsigned CW = 4;
  localparam logic [2:0] BEQ = 3'd0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, pipe_flush, id_valid, id_is_branch;
  logic [2:0] id_btype_op;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
  logic [31:0] id_pc_plus4, id_imm;
  logic ex_regwrite, ex_memread, mem_regwrite, mem_memread, wb_regwrite, b_result;
  logic [2:0] btype_op_out;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic stall, pc_redirect, if_flush, illegal_op;
  logic [31:0] redirect_target;
  logic [CW-1:0] branch_cnt, taken_cnt;

  branch_resolve_ctrl #(.CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst), .i_pipe_flush(pipe_flush),
    .i_id_valid(id_valid), .i_id_is_branch(id_is_branch), .i_id_btype_op(id_btype_op),
    .i_id_rs(id_rs), .i_id_rt(id_rt), .i_id_pc_plus4(id_pc_plus4), .i_id_imm(id_imm),
    .i_ex_regwrite(ex_regwrite), .i_ex_memread(ex_memread), .i_ex_rd(ex_rd),
    .i_mem_regwrite(mem_regwrite), .i_mem_memread(mem_memread), .i_mem_rd(mem_rd),
    .i_wb_regwrite(wb_regwrite), .i_wb_rd(wb_rd), .i_b_result(b_result),
    .o_btype_op_out(btype_op_out), .o_fwd_a_sel(fwd_a_sel), .o_fwd_b_sel(fwd_b_sel),
    .o_stall(stall), .o_pc_redirect(pc_redirect), .o_if_flush(if_flush),
    .o_redirect_target(redirect_target), .o_illegal_op(illegal_op),
    .o_branch_cnt(branch_cnt), .o_taken_cnt(taken_cnt)
  );

  typedef struct {
    string         name;
    logic          st, rd, il;
    logic [1:0]    fa, fb;
    logic [31:0]   tgt;
    logic [2:0]    op;
    logic [CW-1:0] bc, tc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic [CW-1:0] m_bc = '0;
  logic [CW-1:0] m_tc = '0;

  task automatic chk(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %0h want %0h", n, f, act, exp);
    end
  endtask

  // Monitor: compares one expected record per cycle, away from the clock edge.
  exp_t e;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk(e.name, "stall", 32'(stall), 32'(e.st));
      chk(e.name, "pc_redirect", 32'(pc_redirect), 32'(e.rd));
      chk(e.name, "if_flush", 32'(if_flush), 32'(e.rd));
      chk(e.name, "illegal_op", 32'(illegal_op), 32'(e.il));
      chk(e.name, "fwd_a", 32'(fwd_a_sel), 32'(e.fa));
      chk(e.name, "fwd_b", 32'(fwd_b_sel), 32'(e.fb));
      chk(e.name, "target", redirect_target, e.tgt);
      chk(e.name, "op_out", 32'(btype_op_out), 32'(e.op));
      chk(e.name, "branch_cnt", 32'(branch_cnt), 32'(e.bc));
      chk(e.name, "taken_cnt", 32'(taken_cnt), 32'(e.tc));
    end
  end

  task automatic push(input string n, input logic st, input logic rd, input logic il,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] tgt);
    exp_t x;
    x.name = n; x.st = st; x.rd = rd; x.il = il; x.fa = fa; x.fb = fb;
    x.tgt = tgt; x.op = id_btype_op; x.bc = m_bc; x.tc = m_tc;
    q.push_back(x);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    pipe_flush = 0; id_valid = 0; id_is_branch = 0; id_btype_op = BEQ;
    id_rs = 0; id_rt = 0; id_pc_plus4 = 0; id_imm = 0;
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0;
    wb_regwrite = 0; wb_rd = 0; b_result = 0;
  endtask

  task automatic set_br(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic b, input logic [31:0] pc, input logic [31:0] imm);
    id_valid = 1; id_is_branch = 1; id_btype_op = op;
    id_rs = rs; id_rt = rt; b_result = b; id_pc_plus4 = pc; id_imm = imm;
  endtask

  initial begin
    rst = 1;
    clr();
    step();
    push("reset", 0, 0, 0, 0, 0, 32'h0); step();
    rst = 0;

    // No hazard, taken.
    set_br(BEQ, 5'd3, 5'd4, 1, 32'h100, 32'd4);
    push("nohaz", 0, 1, 0, 0, 0, 32'h110); step();
    m_bc++; m_tc++;
    clr(); push("idle1", 0, 0, 0, 0, 0, 32'h0); step();

    // ALU producer in EX: one stall, then forward from MEM.
    set_br(BEQ, 5'd3, 5'd4, 1, 32'h200, 32'd8);
    ex_regwrite = 1; ex_rd = 5'd3;
    push("alu_stall", 1, 0, 0, 0, 0, 32'h220); step();
    ex_regwrite = 0; ex_rd = 0; mem_regwrite = 1; mem_rd = 5'd3;
    push("alu_res", 0, 1, 0, 1, 0, 32'h220); step();
    m_bc++; m_tc++;
    clr(); push("idle2", 0, 0, 0, 0, 0, 32'h0); step();

    // Load-use: two stalls, then forward from WB; negative offset.
    set_br(BEQ, 5'd5, 5'd4, 1, 32'h100, 32'hFFFF_FFFF);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
    push("lu_s1", 1, 0, 0, 0, 0, 32'hFC); step();
    ex_regwrite = 0; ex_memread = 0; ex_rd = 0;
    mem_regwrite = 1; mem_memread = 1; mem_rd = 5'd4;
    push("lu_s2", 1, 0, 0, 0, 0, 32'hFC); step();
    mem_regwrite = 0; mem_memread = 0; mem_rd = 0; wb_regwrite = 1; wb_rd = 5'd4;
    push("lu_res", 0, 1, 0, 0, 2, 32'hFC); step();
    m_bc++; m_tc++;
    clr(); push("idle3", 0, 0, 0, 0, 0, 32'h0); step();

    // Register 0 never hazards or forwards; not taken.
    set_br(BEQ, 5'd0, 5'd6, 0, 32'h40, 32'd2);
    ex_regwrite = 1; ex_rd = 5'd0; wb_regwrite = 1; wb_rd = 5'd0;
    push("reg0", 0, 0, 0, 0, 0, 32'h48); step();
    m_bc++;
    clr(); push("idle4", 0, 0, 0, 0, 0, 32'h0); step();

    // pipe_flush during the first load-use stall cycle.
    set_br(BEQ, 5'd5, 5'd4, 1, 32'h100, 32'd1);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
    push("fl_s1", 1, 0, 0, 0, 0, 32'h104); step();
    pipe_flush = 1;
    push("fl_cyc", 0, 0, 0, 0, 0, 32'h104); step();
    clr(); push("fl_after1", 0, 0, 0, 0, 0, 32'h0); step();
    push("fl_after2", 0, 0, 0, 0, 0, 32'h0); step();

    // Asynchronous reset in the middle of a stall.
    set_br(BEQ, 5'd5, 5'd4, 1, 32'h100, 32'd1);
    ex_regwrite = 1; ex_memread = 1; ex_rd = 5'd4;
    push("rs_s1", 1, 0, 0, 0, 0, 32'h104); step();
    m_bc = '0; m_tc = '0;
    push("rs_async", 0, 0, 0, 0, 0, 32'h104);
    #2 rst = 1;
    step();
    rst = 0;
    clr(); push("rs_after", 0, 0, 0, 0, 0, 32'h0); step();

    // 2^CW taken branches wrap both counters back to 0.
    for (int i = 0; i < (1 << CW); i++) begin
      set_br(BEQ, 5'd1, 5'd2, 1, 32'h0, 32'h0);
      push("wrap", 0, 1, 0, 0, 0, 32'h0); step();
      m_bc++; m_tc++;
    end

    // Unsupported op: illegal pulse, not taken, still counted.
    set_br(3'd5, 5'd1, 5'd2, 1, 32'h10, 32'd1);
    push("illegal", 0, 0, 1, 0, 0, 32'h14); step();
    m_bc++;
    clr(); push("final", 0, 0, 0, 0, 0, 32'h0); step();

    @(negedge clk);
    #1;
    chk("scoreboard", "pending", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
